// File: rtl/generic_channel_merge_fifo_pkg.sv
//==============================================================================
// Package : generic_channel_pkg
// Brief   : Shared constants and helpers for the channel merge FIFO slice.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

package generic_channel_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Channel-index width; a single-bit tag is kept even for tiny channel counts.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/generic_channel_merge_fifo_fifo.sv
//==============================================================================
// Module  : generic_channel_fifo
// Brief   : Single-channel synchronous FIFO with wrap-bit pointers.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module generic_channel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/generic_channel_merge_fifo.sv
//==============================================================================
// Module  : generic_channel_merge_fifo
// Brief   : Per-channel FIFOs merged by an arbiter onto one registered,
//           channel-tagged valid/ready output.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module generic_channel_merge_fifo
    import generic_channel_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  WIDTH    = 8,
    parameter int  DEPTH    = 4,
    parameter int  ARB_MODE = 0,
    localparam int CH_W     = ch_w(NUM_CH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CH-1:0]       i_valid,
    output logic [NUM_CH-1:0]       o_ready,
    input  logic [NUM_CH*WIDTH-1:0] i_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [WIDTH-1:0]        o_data,
    output logic [CH_W-1:0]         o_chan,
    output logic                    o_empty
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CH_W-1:0]  chan;
    } beat_t;

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_nonempty;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [WIDTH-1:0]  w_rdata [NUM_CH];
    logic              w_load;
    logic              w_any;
    logic [CH_W-1:0]   w_gnt;
    logic [CH_W-1:0]   w_cand;

    beat_t             r_beat;
    logic              r_valid;
    logic [CH_W-1:0]   r_last;

    assign o_ready    = i_rst ? '0 : ~w_full;
    assign w_push     = i_valid & o_ready;
    assign w_nonempty = ~w_empty;
    assign w_any      = |w_nonempty;
    assign w_load     = !r_valid || i_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_pop[c] = w_load && w_any && (w_gnt == CH_W'(c));

        generic_channel_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_push  (w_push[c]),
            .i_wdata (i_data[c*WIDTH +: WIDTH]),
            .o_full  (w_full[c]),
            .i_pop   (w_pop[c]),
            .o_empty (w_empty[c]),
            .o_rdata (w_rdata[c])
        );
    end

    // Scan from farthest to nearest so the last hit is the closest eligible channel.
    always_comb begin
        w_gnt  = '0;
        w_cand = '0;
        if (ARB_MODE == ARB_FIXED) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (w_nonempty[i]) w_gnt = CH_W'(i);
            end
        end else begin
            for (int i = NUM_CH; i >= 1; i--) begin
                w_cand = CH_W'((int'(r_last) + i) % NUM_CH);
                if (w_nonempty[w_cand]) w_gnt = w_cand;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
            r_last  <= CH_W'(NUM_CH - 1);
        end else if (w_load) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_beat  <= '{data: w_rdata[w_gnt], chan: w_gnt};
                r_last  <= w_gnt;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_beat.data;
    assign o_chan  = r_beat.chan;
    assign o_empty = i_rst ? 1'b1 : ((&w_empty) && !r_valid);

endmodule

`default_nettype wire

// File: tb/tb_generic_channel_merge_fifo.sv
//==============================================================================
// Module  : tb_generic_channel_merge_fifo
// Brief   : Bench driving a round-robin and a fixed-priority merge FIFO with
//           shared stimulus, checked against per-channel scoreboards.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module tb_generic_channel_merge_fifo;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int CH_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       valid;
    logic [NUM_CH*WIDTH-1:0] data;
    logic                    ready;

    logic [NUM_CH-1:0] rr_ready, fx_ready;
    logic              rr_valid, fx_valid;
    logic [WIDTH-1:0]  rr_data, fx_data;
    logic [CH_W-1:0]   rr_chan, fx_chan;
    logic              rr_empty, fx_empty;

    generic_channel_merge_fifo #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(4), .ARB_MODE(0)) u_rr (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rr_ready), .i_data(data),
        .o_valid(rr_valid), .i_ready(ready), .o_data(rr_data), .o_chan(rr_chan), .o_empty(rr_empty)
    );

    generic_channel_merge_fifo #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(4), .ARB_MODE(1)) u_fx (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(fx_ready), .i_data(data),
        .o_valid(fx_valid), .i_ready(ready), .o_data(fx_data), .o_chan(fx_chan), .o_empty(fx_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic              rst;
        logic [NUM_CH-1:0] valid;
        logic [WIDTH-1:0]  d0;
        logic              rdy;
        logic [NUM_CH-1:0] e_ready;
        logic              e_valid;
        logic              e_empty;
    } vec_t;

    vec_t tbl [7];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [WIDTH-1:0] sb_rr [NUM_CH][$];
    logic [WIDTH-1:0] sb_fx [NUM_CH][$];
    int               rr_log[$], rr_cyc[$], fx_log[$];

    logic             have_hold = 1'b0;
    logic [WIDTH-1:0] hold_d;
    logic [CH_W-1:0]  hold_c;

    int exp_rr [8];
    int exp_fx [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input string name, input int ch, input logic [WIDTH-1:0] act, input logic is_rr);
        logic [WIDTH-1:0] e;
        n_vec++;
        if (is_rr ? (sb_rr[ch].size() == 0) : (sb_fx[ch].size() == 0)) begin
            n_err++;
            $display("FAIL %s_extra: got beat %0h on ch%0d expected none (cycle %0d)", name, act, ch, cyc);
        end else begin
            e = is_rr ? sb_rr[ch].pop_front() : sb_fx[ch].pop_front();
            if (act !== e) begin
                n_err++;
                $display("FAIL %s_data ch%0d: got %0h expected %0h (cycle %0d)", name, ch, act, e, cyc);
            end
        end
    endtask

    // Observes the handshakes the upcoming rising edge will act on.
    task automatic monitor();
        if (have_hold) begin
            check("hold_data", 32'(rr_data), 32'(hold_d));
            check("hold_chan", 32'(rr_chan), 32'(hold_c));
            have_hold = 1'b0;
        end
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sb_rr[c].delete();
                sb_fx[c].delete();
            end
        end else begin
            if (rr_valid && ready) begin
                pop_check("rr", int'(rr_chan), rr_data, 1'b1);
                rr_log.push_back(int'(rr_chan));
                rr_cyc.push_back(cyc);
            end
            if (fx_valid && ready) begin
                pop_check("fx", int'(fx_chan), fx_data, 1'b0);
                fx_log.push_back(int'(fx_chan));
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (valid[c] && rr_ready[c]) sb_rr[c].push_back(data[c*WIDTH +: WIDTH]);
                if (valid[c] && fx_ready[c]) sb_fx[c].push_back(data[c*WIDTH +: WIDTH]);
            end
            if (rr_valid && !ready) begin
                have_hold = 1'b1;
                hold_d    = rr_data;
                hold_c    = rr_chan;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int total;
        rst   = 1'b1;
        valid = '1;
        data  = '0;
        ready = 1'b1;

        tbl[0] = '{"rst0",  1'b1, 4'hF, 8'h00, 1'b1, 4'h0, 1'b0, 1'b1};
        tbl[1] = '{"rst1",  1'b1, 4'hF, 8'h00, 1'b1, 4'h0, 1'b0, 1'b1};
        tbl[2] = '{"rst2",  1'b1, 4'hF, 8'h00, 1'b1, 4'h0, 1'b0, 1'b1};
        tbl[3] = '{"idle",  1'b0, 4'h0, 8'h00, 1'b0, 4'hF, 1'b0, 1'b1};
        tbl[4] = '{"acc",   1'b0, 4'h1, 8'hA0, 1'b0, 4'hF, 1'b0, 1'b0};
        tbl[5] = '{"lat1",  1'b0, 4'h0, 8'h00, 1'b0, 4'hF, 1'b1, 1'b0};
        tbl[6] = '{"drain", 1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 1'b0, 1'b1};
        exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_fx = '{0, 0, 1, 1, 2, 2, 3, 3};

        // Reset and first-beat latency
        for (int i = 0; i < 7; i++) begin
            rst   = tbl[i].rst;
            valid = tbl[i].valid;
            data  = {24'h0, tbl[i].d0};
            ready = tbl[i].rdy;
            tick();
            check({tbl[i].name, "_ready"}, 32'(rr_ready), 32'(tbl[i].e_ready));
            check({tbl[i].name, "_valid"}, 32'(rr_valid), 32'(tbl[i].e_valid));
            check({tbl[i].name, "_empty"}, 32'(rr_empty), 32'(tbl[i].e_empty));
            if (i == 2) begin
                check("rst_data", 32'(rr_data), 32'h0);
                check("rst_chan", 32'(rr_chan), 32'h0);
            end
        end

        // Fill channel 2 against backpressure
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid = 4'b0100;
            data  = {8'h00, 8'(8'h10 + i), 16'h0};
            tick();
            check("fill_ready2", 32'(rr_ready[2]), (i < 4) ? 32'd1 : 32'd0);
        end
        check("fill_head", 32'(rr_data), 32'h10);
        valid = 4'b0100;
        data  = {8'h00, 8'h15, 16'h0};
        ready = 1'b1;
        tick();
        check("full_pop_ready2", 32'(rr_ready[2]), 32'd1);
        tick();
        valid = '0;
        for (int i = 0; i < 8; i++) tick();
        check("fill_drained", 32'(rr_empty), 32'd1);

        // Arbitration: reset the RR pointer, load 2 beats per channel
        rst   = 1'b1;
        ready = 1'b0;
        tick();
        rst = 1'b0;
        rr_log.delete();
        rr_cyc.delete();
        fx_log.delete();
        valid = '1;
        data  = {8'h23, 8'h22, 8'h21, 8'h20};
        tick();
        data  = {8'h33, 8'h32, 8'h31, 8'h30};
        tick();
        valid = '0;
        ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("rr_count", 32'(rr_log.size()), 32'd8);
        check("fx_count", 32'(fx_log.size()), 32'd8);
        if (rr_log.size() == 8 && fx_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("rr_chan_seq", 32'(rr_log[i]), 32'(exp_rr[i]));
                check("fx_chan_seq", 32'(fx_log[i]), 32'(exp_fx[i]));
                check("rr_no_bubble", 32'(rr_cyc[i] - rr_cyc[0]), 32'(i));
            end
        end

        // Backpressure: i_ready toggling during a two-channel stream
        for (int i = 0; i < 10; i++) begin
            valid = (i < 3) ? 4'b1010 : 4'b0000;
            data  = {8'(8'h50 + i), 8'h00, 8'(8'h40 + i), 8'h00};
            ready = (i % 2 == 0);
            tick();
        end
        valid = '0;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("bp_drained", 32'(rr_empty), 32'd1);

        // Reset with beats buffered: none may ever emerge
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid = 4'b0001;
            data  = {24'h0, 8'(8'h60 + i)};
            tick();
        end
        valid = '0;
        check("pre_rst_valid", 32'(rr_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rr_valid), 32'd0);
        check("mid_rst_empty", 32'(rr_empty), 32'd1);
        check("mid_rst_fx_empty", 32'(fx_empty), 32'd1);
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_valid", 32'(rr_valid | fx_valid), 32'd0);
        end

        total = 0;
        for (int c = 0; c < NUM_CH; c++) total += sb_rr[c].size() + sb_fx[c].size();
        check("leftover_beats", 32'(total), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
